mem_dump_reader: RTL and testbench

Read-side counterpart of the program-load write port (we0 / wr_addr0 / wr_din0) on Top_Module_Pipe memories. On a start command it sequentially reads a block of words through a one-cycle-latency synchronous read port and streams them out over a valid/ready interface with backpressure. Benches and the debug path use it to dump data or instruction memory after a run, while it holds the core's PC in reset.

---
 rtl/mem_dump_if.sv | 24 ++
 rtl/mem_dump_reader.sv | 137 +++++++++++++
 tb/tb_mem_dump_reader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_if.sv
// Memory read port plus output stream of the memory dump reader.
// master = reader side, slave = memory/sink side.
interface mem_dump_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              rd_en0;
  logic [ADDR_W-1:0] rd_addr0;
  logic [DATA_W-1:0] rd_dout0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_ready;

  modport master (
    output rd_en0, rd_addr0, out_valid, out_data, out_addr,
    input  rd_dout0, out_ready
  );

  modport slave (
    input  rd_en0, rd_addr0, out_valid, out_data, out_addr,
    output rd_dout0, out_ready
  );
endinterface

// File: rtl/mem_dump_reader.sv
// Streams a block of words from a one-cycle-latency memory port over valid/ready,
// holding the core PC in reset while busy.
//
// state | meaning
// IDLE  | waiting for start; count-0 commands complete here
// RUN   | issuing reads while credit is available
// FLUSH | all reads issued, draining in-flight word and FIFO
module mem_dump_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  mem_dump_if.master        bus,
  output logic              busy,
  output logic              hold_pc,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              inflight_q;
  logic              done_q, done_d;
  logic              issue, push, pop;
  logic [1:0]        credit_used;
  logic              base_lsb_unused;

  logic [DATA_W-1:0] fifo_data [2];
  logic [ADDR_W-1:0] fifo_addr [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;

  assign base_lsb_unused = ^base_addr[1:0];

  assign push = inflight_q;
  assign pop  = (fifo_cnt != 2'd0) && bus.out_ready;
  // A word leaving this cycle frees its slot immediately, so a steady ready
  // stream sustains one word per cycle.
  assign credit_used = fifo_cnt + {1'b0, inflight_q} - {1'b0, pop};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = {base_addr[ADDR_W-1:2], 2'b00};
          remaining_d = word_count;
          if (word_count == '0) done_d  = 1'b1;
          else                  state_d = RUN;
        end
      end
      RUN: begin
        if (remaining_q != '0 && credit_used < 2'd2) begin
          issue       = 1'b1;
          addr_d      = addr_q + ADDR_W'(4);
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!inflight_q && (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= issue;
      done_q      <= done_d;
      if (issue) last_addr_q <= addr_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_addr[0] <= '0;
      fifo_addr[1] <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_cnt     <= 2'd0;
    end else begin
      // last_addr_q still names the word in flight on the capture edge
      if (push) begin
        fifo_data[wr_ptr] <= bus.rd_dout0;
        fifo_addr[wr_ptr] <= last_addr_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && fifo_cnt == 2'd2));

  assign bus.rd_en0    = issue;
  assign bus.rd_addr0  = issue ? addr_q : last_addr_q;
  assign bus.out_valid = (fifo_cnt != 2'd0);
  assign bus.out_data  = fifo_data[rd_ptr];
  assign bus.out_addr  = fifo_addr[rd_ptr];
  assign busy          = (state_q != IDLE);
  assign hold_pc       = busy;
  assign done          = done_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader: memory model, stream checker, timing checks.
module tb_mem_dump_reader;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              busy, hold_pc, done;

  mem_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .bus        (bus.master),
    .busy       (busy),
    .hold_pc    (hold_pc),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [128];
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int issued = 0, hs_total = 0, cmd_hs = 0, first_hs = 0, last_hs = 0;
  bit prev_stall = 0;
  logic [ADDR_W+DATA_W-1:0] prev_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.rd_en0) bus.rd_dout0 <= mem[bus.rd_addr0[8:2]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      issued     = 0;
      hs_total   = 0;
      prev_stall = 0;
    end else begin
      exp_t e;
      if (bus.rd_en0) issued++;
      if (prev_stall) check("stall_hold", 64'({bus.out_addr, bus.out_data}), 64'(prev_word));
      if (bus.out_valid && bus.out_ready) begin
        hs_total++;
        cmd_hs++;
        if (cmd_hs == 1) first_hs = cyc;
        last_hs = cyc;
        if (sb.size() == 0) begin
          check("unexpected_word", 64'(bus.out_addr), 64'h1FF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("out_data", 64'(bus.out_data), 64'(e.data));
          check("out_addr", 64'(bus.out_addr), 64'(e.addr));
        end
      end
      if (bus.rd_en0) check("credit_le_2", 64'(issued - hs_total <= 2), 64'd1);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = {bus.out_addr, bus.out_data};
    end
  end

  task automatic run_cmd(input logic [ADDR_W-1:0] base, input int n, input bit throttle,
                         input bit immediate);
    int e0;
    bit seen_done;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = {base[8:2], 2'b00} + ADDR_W'(4 * i);
      sb.push_back('{addr: a, data: mem[a[8:2]]});
    end
    if (!immediate) begin
      @(posedge clk); #1;
    end
    cmd_hs     = 0;
    start      = 1'b1;
    base_addr  = base;
    word_count = CNT_W'(n);
    e0         = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      check("zero_done", 64'(done), 64'd1);
      check("zero_busy", 64'(busy), 64'd0);
      check("zero_rd_en", 64'(bus.rd_en0), 64'd0);
      check("zero_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      check("zero_done_drop", 64'(done), 64'd0);
      check("zero_busy_after", 64'(busy), 64'd0);
      return;
    end
    check("busy_after_start", 64'(busy), 64'd1);
    check("hold_pc_after_start", 64'(hold_pc), 64'd1);
    check("first_rd_en", 64'(bus.rd_en0), 64'd1);
    check("first_rd_addr", 64'(bus.rd_addr0), 64'({base[8:2], 2'b00}));
    seen_done = 0;
    for (int k = 0; k < 200; k++) begin
      bus.out_ready = throttle ? (k % 3 == 0) : 1'b1;
      // a start pulse while busy must be ignored
      start      = (k == 1);
      base_addr  = 9'h1F0;
      word_count = 8'd5;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        seen_done = 1;
        break;
      end
    end
    if (!seen_done) begin
      check("done_timeout", 64'd0, 64'd1);
      bus.out_ready = 1'b1;
      return;
    end
    check("done_after_last_hs", 64'(cyc), 64'(last_hs + 1));
    check("busy_at_done", 64'(busy), 64'd0);
    check("words_seen", 64'(cmd_hs), 64'(n));
    check("sb_empty", 64'(sb.size()), 64'd0);
    if (!throttle) begin
      check("first_hs_cycle", 64'(first_hs), 64'(e0 + 2));
      check("last_hs_cycle", 64'(last_hs), 64'(e0 + n + 1));
    end
  endtask

  task automatic mid_reset_test();
    logic [ADDR_W-1:0] a;
    bit hit;
    for (int i = 0; i < 8; i++) begin
      a = 9'h040 + ADDR_W'(4 * i);
      sb.push_back('{addr: a, data: mem[a[8:2]]});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    cmd_hs     = 0;
    start      = 1'b1;
    base_addr  = 9'h040;
    word_count = 8'd8;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (cmd_hs == 3) begin
        hit = 1;
        break;
      end
    end
    check("third_word_reached", 64'(hit), 64'd1);
    reset = 1'b0;
    #1;
    check("rst_rd_en", 64'(bus.rd_en0), 64'd0);
    check("rst_rd_addr", 64'(bus.rd_addr0), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    check("rst_addr", 64'(bus.out_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hold_pc", 64'(hold_pc), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    sb.delete();
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_done", 64'(done), 64'd0);
    end
    #2 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("post_rst_no_done", 64'(done), 64'd0);
      check("post_rst_idle", 64'(busy | bus.out_valid), 64'd0);
    end
    run_cmd(9'h020, 2, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + 32'(i);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_en", 64'(bus.rd_en0), 64'd0);
    check("reset_rd_addr", 64'(bus.rd_addr0), 64'd0);
    check("reset_valid", 64'(bus.out_valid), 64'd0);
    check("reset_data", 64'(bus.out_data), 64'd0);
    check("reset_out_addr", 64'(bus.out_addr), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hold_pc", 64'(hold_pc), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;

    run_cmd(9'h000, 4, 0, 0);
    run_cmd(9'h000, 4, 1, 0);
    run_cmd(9'h1FC, 3, 0, 0);
    run_cmd(9'h000, 0, 0, 0);
    run_cmd(9'h00A, 2, 0, 0);
    run_cmd(9'h080, 3, 1, 0);
    run_cmd(9'h100, 2, 0, 1);
    mid_reset_test();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
